// File: rtl/cdb_arbiter_if.sv
// Common data bus: two result lanes driven by the arbiter and snooped by the
// ROB, reservation stations and rename table.
interface cdb_if #(
    parameter int TAG_WIDTH = 6
) ();
    logic [1:0]                valid;
    logic [1:0][TAG_WIDTH-1:0] tag;
    logic [1:0][31:0]          data;
    logic [1:0]                exception;

    modport producer (output valid, tag, data, exception);
    modport consumer (input  valid, tag, data, exception);
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: buffers functional-unit results in per-FU FIFOs and grants up
// to two of them per cycle, round-robin, onto the registered CDB lanes.
// Lane 1 is only ever used when lane 0 is used, so consumers see packed lanes.
module cdb_arbiter #(
    parameter int N_FU      = 4,
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [N_FU-1:0]                fu_valid_i,
    output logic [N_FU-1:0]                fu_ready_o,
    input  logic [N_FU-1:0][TAG_WIDTH-1:0] fu_tag_i,
    input  logic [N_FU-1:0][31:0]          fu_data_i,
    input  logic [N_FU-1:0]                fu_exc_i,
    cdb_if.producer                        cdb
);

    localparam int IDX_W = $clog2(N_FU);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + TAG_WIDTH + 32;

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FU - 1);

    // Stage 0: per-FU result FIFOs; entry layout is {exception, tag, data}
    logic [ENT_W-1:0] mem_p0  [N_FU][DEPTH];
    logic [PTR_W-1:0] wptr_p0 [N_FU];
    logic [PTR_W-1:0] rptr_p0 [N_FU];
    logic [CNT_W-1:0] cnt_p0  [N_FU];
    logic [IDX_W-1:0] rr_ptr;

    logic [N_FU-1:0]            push;
    logic [N_FU-1:0]            pop;
    logic [1:0]                 gnt_vld;
    logic [1:0][IDX_W-1:0]      gnt_idx;
    logic [1:0][ENT_W-1:0]      head;
    logic [IDX_W-1:0]           last_idx;
    logic [IDX_W-1:0]           rr_nxt;
    int                         scan_idx;

    // Round-robin scan from rr_ptr: first non-empty FIFO feeds lane 0, second lane 1
    always_comb begin
        gnt_vld  = '0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < N_FU; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_FU) begin
                scan_idx = scan_idx - N_FU;
            end
            if (cnt_p0[scan_idx] != '0) begin
                if (!gnt_vld[0]) begin
                    gnt_vld[0] = 1'b1;
                    gnt_idx[0] = IDX_W'(scan_idx);
                end else if (!gnt_vld[1]) begin
                    gnt_vld[1] = 1'b1;
                    gnt_idx[1] = IDX_W'(scan_idx);
                end
            end
        end
    end

    // Head entries of the granted FIFOs and the pointer the next scan starts from
    always_comb begin
        head[0]  = mem_p0[gnt_idx[0]][rptr_p0[gnt_idx[0]]];
        head[1]  = mem_p0[gnt_idx[1]][rptr_p0[gnt_idx[1]]];
        last_idx = gnt_vld[1] ? gnt_idx[1] : gnt_idx[0];
        rr_nxt   = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
    end

    // Ready depends only on registered occupancy; push/pop strobes per FU
    always_comb begin
        fu_ready_o = '0;
        push       = '0;
        pop        = '0;
        for (int i = 0; i < N_FU; i++) begin
            fu_ready_o[i] = (cnt_p0[i] != FULL);
            push[i]       = fu_valid_i[i] && fu_ready_o[i];
            pop[i]        = (gnt_vld[0] && (gnt_idx[0] == IDX_W'(i))) ||
                            (gnt_vld[1] && (gnt_idx[1] == IDX_W'(i)));
        end
    end

    // FIFO control and round-robin pointer; flush discards everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rr_ptr <= '0;
            for (int i = 0; i < N_FU; i++) begin
                cnt_p0[i]  <= '0;
                wptr_p0[i] <= '0;
                rptr_p0[i] <= '0;
            end
        end else begin
            if (gnt_vld[0]) begin
                rr_ptr <= rr_nxt;
            end
            for (int i = 0; i < N_FU; i++) begin
                if (push[i]) begin
                    wptr_p0[i] <= wptr_p0[i] + 1'b1;
                end
                if (pop[i]) begin
                    rptr_p0[i] <= rptr_p0[i] + 1'b1;
                end
                cnt_p0[i] <= cnt_p0[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // FIFO storage writes; contents are only meaningful under the counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (push[i]) begin
                mem_p0[i][wptr_p0[i]] <= {fu_exc_i[i], fu_tag_i[i], fu_data_i[i]};
            end
        end
    end

    // Stage 1: CDB lane registers; payload holds when its lane is not granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb.valid     <= '0;
            cdb.tag       <= '0;
            cdb.data      <= '0;
            cdb.exception <= '0;
        end else if (flush) begin
            cdb.valid <= '0;
        end else begin
            cdb.valid <= gnt_vld;
            for (int k = 0; k < 2; k++) begin
                if (gnt_vld[k]) begin
                    cdb.exception[k] <= head[k][ENT_W-1];
                    cdb.tag[k]       <= head[k][32 +: TAG_WIDTH];
                    cdb.data[k]      <= head[k][31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model
// predicts the CDB contents after every edge; a monitor compares them.
module tb_cdb_arbiter;

    localparam int N_FU  = 4;
    localparam int DEPTH = 2;
    localparam int TW    = 6;

    typedef struct packed {
        logic [1:0]         valid;
        logic [1:0][TW-1:0] tag;
        logic [1:0][31:0]   data;
        logic [1:0]         exc;
    } cdb_rec_t;

    typedef struct packed {
        logic          exc;
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } res_t;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic [N_FU-1:0]         fu_valid_i = '0;
    logic [N_FU-1:0]         fu_ready_o;
    logic [N_FU-1:0][TW-1:0] fu_tag_i  = '0;
    logic [N_FU-1:0][31:0]   fu_data_i = '0;
    logic [N_FU-1:0]         fu_exc_i  = '0;

    cdb_if #(.TAG_WIDTH(TW)) cdb ();

    cdb_arbiter #(.N_FU(N_FU), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fu_valid_i (fu_valid_i),
        .fu_ready_o (fu_ready_o),
        .fu_tag_i   (fu_tag_i),
        .fu_data_i  (fu_data_i),
        .fu_exc_i   (fu_exc_i),
        .cdb        (cdb)
    );

    always #5 clk = ~clk;

    // Reference model state: pending results per FU, scan start, lane contents
    res_t     mq [N_FU][$];
    int       m_rr;
    cdb_rec_t m_out;
    cdb_rec_t sb [$];
    cdb_rec_t mon_exp;

    // Next-cycle input values used by step()
    logic [N_FU-1:0][TW-1:0] nt;
    logic [N_FU-1:0][31:0]   nd;
    logic [N_FU-1:0]         ne;

    int vectors     = 0;
    int miscompares = 0;
    int tag_ctr     = 0;

    // One clock cycle: check ready, drive inputs, advance the model, queue expectation
    task automatic step(input logic r, input logic f, input logic [N_FU-1:0] v);
        logic [N_FU-1:0] rdy;
        int   lane;
        int   last;
        int   idx;
        res_t h;
        @(negedge clk);
        for (int i = 0; i < N_FU; i++) rdy[i] = (mq[i].size() < DEPTH);
        vectors++;
        if (fu_ready_o !== rdy) begin
            miscompares++;
            $display("FAIL fu_ready t=%0t got %b want %b", $time, fu_ready_o, rdy);
        end
        rst_n      = r;
        flush      = f;
        fu_valid_i = v;
        fu_tag_i   = nt;
        fu_data_i  = nd;
        fu_exc_i   = ne;
        if (!r) begin
            for (int i = 0; i < N_FU; i++) mq[i].delete();
            m_rr  = 0;
            m_out = '0;
        end else if (f) begin
            for (int i = 0; i < N_FU; i++) mq[i].delete();
            m_rr        = 0;
            m_out.valid = '0;
        end else begin
            m_out.valid = '0;
            lane = 0;
            last = 0;
            for (int k = 0; k < N_FU; k++) begin
                idx = (m_rr + k) % N_FU;
                if (lane < 2 && mq[idx].size() > 0) begin
                    h = mq[idx].pop_front();
                    m_out.valid[lane] = 1'b1;
                    m_out.tag[lane]   = h.tag;
                    m_out.data[lane]  = h.data;
                    m_out.exc[lane]   = h.exc;
                    last = idx;
                    lane++;
                end
            end
            if (lane > 0) m_rr = (last + 1) % N_FU;
            for (int i = 0; i < N_FU; i++) begin
                if (v[i] && rdy[i]) begin
                    h.exc  = ne[i];
                    h.tag  = nt[i];
                    h.data = nd[i];
                    mq[i].push_back(h);
                end
            end
        end
        sb.push_back(m_out);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 1'b0, '0);
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [31:0] d, input logic e);
        nt[i] = t;
        nd[i] = d;
        ne[i] = e;
    endtask

    task automatic fresh_tags();
        for (int i = 0; i < N_FU; i++) begin
            tag_ctr++;
            set_fu(i, TW'(tag_ctr), $urandom, 1'($urandom));
        end
    endtask

    // Monitor: after each edge compare the bus against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                vectors++;
                if (cdb.valid !== mon_exp.valid) begin
                    miscompares++;
                    $display("FAIL cdb_valid t=%0t got %b want %b", $time, cdb.valid, mon_exp.valid);
                end
                vectors++;
                if ({cdb.tag, cdb.data, cdb.exception} !== {mon_exp.tag, mon_exp.data, mon_exp.exc}) begin
                    miscompares++;
                    $display("FAIL cdb_payload t=%0t got tag=%h/%h data=%h/%h exc=%b want tag=%h/%h data=%h/%h exc=%b",
                             $time, cdb.tag[0], cdb.tag[1], cdb.data[0], cdb.data[1], cdb.exception,
                             mon_exp.tag[0], mon_exp.tag[1], mon_exp.data[0], mon_exp.data[1], mon_exp.exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized phase
    initial begin
        nt = '0;
        nd = '0;
        ne = '0;

        // reset held for two cycles
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        idle(2);

        // single result from FU2
        set_fu(2, 6'd5, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 1'b0, 4'b0100);
        idle(3);

        // return rr to 0, then three-way contention
        step(1'b1, 1'b1, '0);
        set_fu(0, 6'd1, 32'h1111_0001, 1'b0);
        set_fu(1, 6'd2, 32'h2222_0002, 1'b0);
        set_fu(3, 6'd3, 32'h3333_0003, 1'b0);
        step(1'b1, 1'b0, 4'b1011);
        idle(3);

        // move rr to 3, then wrap with an exception result
        set_fu(2, 6'd7, 32'h7777_0007, 1'b0);
        step(1'b1, 1'b0, 4'b0100);
        set_fu(3, 6'd9, 32'h9999_0009, 1'b1);
        set_fu(0, 6'd4, 32'h4444_0004, 1'b0);
        step(1'b1, 1'b0, 4'b1001);
        idle(3);

        // saturation: every FU pushes every cycle
        for (int c = 0; c < 24; c++) begin
            fresh_tags();
            step(1'b1, 1'b0, 4'b1111);
        end
        // reset in the middle of saturated traffic
        fresh_tags();
        step(1'b0, 1'b0, 4'b1111);
        idle(3);

        // build up five pending results, then flush with pushes present
        fresh_tags();
        step(1'b1, 1'b0, 4'b1111);
        fresh_tags();
        step(1'b1, 1'b0, 4'b0111);
        fresh_tags();
        step(1'b1, 1'b1, 4'b1111);
        idle(4);

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 300; c++) begin
            logic r;
            logic f;
            logic [N_FU-1:0] v;
            fresh_tags();
            v = N_FU'($urandom);
            f = ($urandom_range(0, 39) == 0);
            r = !($urandom_range(0, 149) == 0);
            step(r, f, v);
        end
        idle(6);

        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
